rv_regfile_sb: RTL and testbench
================================

Name: rv_regfile_sb

Overview:
- Parametrised successor to the core's integer register file.
- Generalised XLEN, register count and read-port count.
- Two write-back ports, each with its own per-port load-extension mode, plus same-cycle write-to-read bypass.
- Integrated scoreboard (busy bit per register) that the decode stage uses to raise a RAW stall.
- Sits between decode (reads, reservations) and the ALU/LSU write-back stages.

Parameters:
- XLEN, 64, register and data width (32 or 64).
- NREG, 32, number of architectural registers (power of two, ≥2).
- AW, 5, address width; must equal log2(NREG).
- NRD, 2, number of read ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- wen0  in  1  write-back port 0 enable (ALU path).
- waddr0  in  AW  port 0 address.
- wdata0  in  XLEN  port 0 data.
- wext0  in  3  port 0 extension mode.
- wclr0  in  1  clear busy bit of waddr0 on this write.
- wen1  in  1  write-back port 1 enable (LSU path).
- waddr1  in  AW  port 1 address.
- wdata1  in  XLEN  port 1 data.
- wext1  in  3  port 1 extension mode.
- wclr1  in  1  clear busy bit of waddr1 on this write.
- rsv_en  in  1  reserve destination (set busy).
- rsv_addr  in  AW  register to reserve.
- rd_en  in  NRD  per-port read-valid, used for stall qualification only.
- rd_addr  in  NRD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_busy  out  NRD  per-port operand-not-ready.
- stall  out  1  OR over i of (rd_en[i] & rd_busy[i]).
- wcollide  out  1  sticky: both write ports hit the same nonzero register in one cycle.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All registers cleared to 0.
  - All busy bits cleared.
  - wcollide cleared.
- Outputs after reset with no writes:
  - rd_data = 0, rd_busy = 0, stall = 0.
- Extension applied to the write data before storage and before bypass:
  - 0: raw.
  - 1: sign-extend [31:0].
  - 2: zero-extend [31:0].
  - 3: sign-extend [15:0].
  - 4: zero-extend [15:0].
  - 5: sign-extend [7:0].
  - 6: zero-extend [7:0].
  - 7: raw.
  - When XLEN=32, modes 1/2 are equivalent to raw.
- Write timing:
  - The registered value updates at posedge clk when wenN=1 and waddrN≠0.
  - Writes to x0 are ignored entirely: no data update, no busy effect, no collision.
- Write collision (wen0 & wen1, waddr0==waddr1≠0):
  - Port 1 data wins (LSU result is younger).
  - Both wclr apply.
  - wcollide is set at the next edge and held until reset.
- Read:
  - rd_addr[i]==0 returns 0.
  - Otherwise returns the stored value, with combinational bypass.
  - If wen1 & waddr1==rd_addr[i], return the extended wdata1.
  - Else if wen0 & waddr0==rd_addr[i], return the extended wdata0.
  - Else return the array value.
- Scoreboard:
  - busy[x0] is constant 0.
  - At posedge, a register's busy bit is cleared when wenN & wclrN target it.
  - At posedge, a register's busy bit is set when rsv_en targets it (rsv_addr≠0).
  - Same register cleared and reserved in one cycle: set wins (new producer issued).
  - Reserving an already-busy register leaves it busy (no count; single outstanding producer assumed by issue logic).
- rd_busy[i]:
  - Equals busy[rd_addr[i]], except it reads 0 when the same cycle carries a clearing write to rd_addr[i] (bypass makes the operand ready).
  - A same-cycle rsv_en to rd_addr[i] does not affect rd_busy[i] until the next cycle.
- A write without wclr updates data but leaves busy unchanged.
- Reset mid-operation: all pending busy bits are dropped and data is zeroed. Write-back ports must not assume reservations survive reset.

Test Plan:
- Reset, then read x0..x31 on both ports -> all rd_data=0, rd_busy=0, stall=0.
- wen0=1, waddr0=5, wdata0=0x0000_0000_8000_0001, wext0=1 -> same-cycle rd_addr[0]=5 returns 0xFFFF_FFFF_8000_0001; next cycle stored value is identical.
- wen1=1, waddr1=7, wdata1=0xAB, wext1=5 -> x7 = 0xFFFF_FFFF_FFFF_FFAB; with wext1=6 -> 0x0000_0000_0000_00AB.
- rsv_en to x3, next cycle rd_en[1]=1, rd_addr[1]=3 -> rd_busy[1]=1, stall=1. Then wen1 with wclr1=1 to x3 -> same cycle rd_busy[1]=0, stall=0, rd_data = new data.
- Same cycle: wen0 (wclr0=1) to x9 and rsv_en to x9 -> next cycle busy[9]=1.
- Same cycle: wen0 to x4 with 0x11 and wen1 to x4 with 0x22 -> x4 = 0x22, wcollide=1 held. A later write to x0 with rsv_en to x0 -> no state change, rd of x0 = 0.

Source files
------------

// File: rtl/rv_regfile_sb_if.sv
// Decode/write-back side bundle of the scoreboarded register file.
// Whoever drives the writes, reservations and reads uses master; the register file uses slave.
interface rv_regfile_sb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
);
  logic                wen0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic [2:0]          wext0;
  logic                wclr0;
  logic                wen1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic [2:0]          wext1;
  logic                wclr1;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                stall;
  logic                wcollide;

  modport master (
    output wen0, waddr0, wdata0, wext0, wclr0,
    output wen1, waddr1, wdata1, wext1, wclr1,
    output rsv_en, rsv_addr, rd_en, rd_addr,
    input  rd_data, rd_busy, stall, wcollide
  );

  modport slave (
    input  wen0, waddr0, wdata0, wext0, wclr0,
    input  wen1, waddr1, wdata1, wext1, wclr1,
    input  rsv_en, rsv_addr, rd_en, rd_addr,
    output rd_data, rd_busy, stall, wcollide
  );
endinterface

// File: rtl/rv_regfile_sb.sv
// Integer register file with two extending write-back ports, write-to-read bypass
// and a per-register busy scoreboard used by decode to raise RAW stalls.
module rv_regfile_sb #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) (
  input logic           clk,
  input logic           rst_n,
  rv_regfile_sb_if.slave bus
);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [NREG-1:0]     busy_q, busy_d;
  logic                wcollide_q;

  logic [XLEN-1:0]     wd0_ext, wd1_ext;
  logic                we0, we1, clr0, clr1, rsv, collide;
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]      rd_busy_d;

  // Size casts of a signed slice sign-extend; of an unsigned slice zero-extend.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] mode);
    case (mode)
      3'd1:    extend = XLEN'(signed'(d[31:0]));
      3'd2:    extend = XLEN'(d[31:0]);
      3'd3:    extend = XLEN'(signed'(d[15:0]));
      3'd4:    extend = XLEN'(d[15:0]);
      3'd5:    extend = XLEN'(signed'(d[7:0]));
      3'd6:    extend = XLEN'(d[7:0]);
      default: extend = d;
    endcase
  endfunction

  assign wd0_ext = extend(bus.wdata0, bus.wext0);
  assign wd1_ext = extend(bus.wdata1, bus.wext1);

  assign we0     = bus.wen0 && (bus.waddr0 != '0);
  assign we1     = bus.wen1 && (bus.waddr1 != '0);
  assign clr0    = we0 && bus.wclr0;
  assign clr1    = we1 && bus.wclr1;
  assign rsv     = bus.rsv_en && (bus.rsv_addr != '0);
  assign collide = we0 && we1 && (bus.waddr0 == bus.waddr1);

  // Reservation is applied after the clears so a new producer overrides a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clr0) busy_d[bus.waddr0] = 1'b0;
    if (clr1) busy_d[bus.waddr1] = 1'b0;
    if (rsv)  busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Port 1 is written last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      wcollide_q <= 1'b0;
    end else begin
      if (we0) regs_q[bus.waddr0] <= wd0_ext;
      if (we1) regs_q[bus.waddr1] <= wd1_ext;
      busy_q <= busy_d;
      if (collide) wcollide_q <= 1'b1;
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] ra;
      ra = bus.rd_addr[i*AW +: AW];
      if (ra != '0) begin
        if (we1 && (bus.waddr1 == ra)) begin
          rd_data_d[i*XLEN +: XLEN] = wd1_ext;
        end else if (we0 && (bus.waddr0 == ra)) begin
          rd_data_d[i*XLEN +: XLEN] = wd0_ext;
        end else begin
          rd_data_d[i*XLEN +: XLEN] = regs_q[ra];
        end
        // A clearing write in flight is bypassed, so the operand is already ready.
        rd_busy_d[i] = busy_q[ra] && !(clr0 && (bus.waddr0 == ra))
                                  && !(clr1 && (bus.waddr1 == ra));
      end
    end
  end

  assign bus.rd_data  = rd_data_d;
  assign bus.rd_busy  = rd_busy_d;
  assign bus.stall    = |(bus.rd_en & rd_busy_d);
  assign bus.wcollide = wcollide_q;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Scoreboard bench for rv_regfile_sb: directed scenarios plus randomized traffic checked
// against an array-based reference model.
module tb_rv_regfile_sb;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic              rst_n;
    logic              wen0, wclr0, wen1, wclr1, rsv_en;
    logic [AW-1:0]     waddr0, waddr1, rsv_addr;
    logic [XLEN-1:0]   wdata0, wdata1;
    logic [2:0]        wext0, wext1;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
  } stim_t;

  typedef struct {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic                stall;
    logic                wcollide;
    int                  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  longint unsigned m_reg [NREG];
  bit              m_busy[NREG];
  bit              m_coll;

  function automatic longint unsigned ext_model(longint unsigned d, int mode);
    case (mode)
      1:       return $signed(d << 32) >>> 32;
      2:       return d & 64'hFFFF_FFFF;
      3:       return $signed(d << 48) >>> 48;
      4:       return d & 64'hFFFF;
      5:       return $signed(d << 56) >>> 56;
      6:       return d & 64'hFF;
      default: return d;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1;
    s.wen0 = 0; s.wclr0 = 0; s.wen1 = 0; s.wclr1 = 0; s.rsv_en = 0;
    s.waddr0 = '0; s.waddr1 = '0; s.rsv_addr = '0;
    s.wdata0 = '0; s.wdata1 = '0; s.wext0 = '0; s.wext1 = '0;
    s.rd_en = '0; s.rd_addr = '0;
    return s;
  endfunction

  // Drive one cycle, queue the expected response from the pre-edge model state,
  // then advance the model to what the next edge should leave behind.
  task automatic apply(input stim_t s);
    exp_t            e;
    longint unsigned v0, v1;
    int              a, a0, a1;
    @(posedge clk);
    #1;
    cyc++;
    rst_n        = s.rst_n;
    bus.wen0     = s.wen0;   bus.waddr0 = s.waddr0; bus.wdata0 = s.wdata0;
    bus.wext0    = s.wext0;  bus.wclr0  = s.wclr0;
    bus.wen1     = s.wen1;   bus.waddr1 = s.waddr1; bus.wdata1 = s.wdata1;
    bus.wext1    = s.wext1;  bus.wclr1  = s.wclr1;
    bus.rsv_en   = s.rsv_en; bus.rsv_addr = s.rsv_addr;
    bus.rd_en    = s.rd_en;  bus.rd_addr  = s.rd_addr;

    v0 = ext_model(s.wdata0, int'(s.wext0));
    v1 = ext_model(s.wdata1, int'(s.wext1));
    a0 = int'(s.waddr0);
    a1 = int'(s.waddr1);

    if (s.rst_n) begin
      e.stall = 1'b0;
      for (int i = 0; i < NRD; i++) begin
        a = int'(s.rd_addr[i*AW +: AW]);
        if (a == 0)                    e.data[i*XLEN +: XLEN] = '0;
        else if (s.wen1 && a1 == a)    e.data[i*XLEN +: XLEN] = v1;
        else if (s.wen0 && a0 == a)    e.data[i*XLEN +: XLEN] = v0;
        else                           e.data[i*XLEN +: XLEN] = m_reg[a];
        e.busy[i] = (a != 0) && m_busy[a] && !(s.wen0 && s.wclr0 && a0 == a)
                                          && !(s.wen1 && s.wclr1 && a1 == a);
        if (s.rd_en[i] && e.busy[i]) e.stall = 1'b1;
      end
      e.wcollide = m_coll;
      e.cyc      = cyc;
      exp_q.push_back(e);
    end

    if (!s.rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        m_reg[r]  = 0;
        m_busy[r] = 0;
      end
      m_coll = 0;
    end else begin
      if (s.wen0 && a0 != 0) m_reg[a0] = v0;
      if (s.wen1 && a1 != 0) m_reg[a1] = v1;
      if (s.wen0 && s.wclr0 && a0 != 0) m_busy[a0] = 0;
      if (s.wen1 && s.wclr1 && a1 != 0) m_busy[a1] = 0;
      if (s.rsv_en && s.rsv_addr != 0) m_busy[int'(s.rsv_addr)] = 1;
      if (s.wen0 && s.wen1 && a0 == a1 && a0 != 0) m_coll = 1;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp,
                     input int c);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // Monitor: outputs settle after the #1 drive and are sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data",  128'(bus.rd_data),  128'(e.data),     e.cyc);
        chk("rd_busy",  128'(bus.rd_busy),  128'(e.busy),     e.cyc);
        chk("stall",    128'(bus.stall),    128'(e.stall),    e.cyc);
        chk("wcollide", 128'(bus.wcollide), 128'(e.wcollide), e.cyc);
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    stim_t s;
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = 0;
      m_busy[r] = 0;
    end
    m_coll = 0;

    s = idle();
    s.rst_n = 1'b0;
    apply(s);
    apply(s);

    // Every register reads zero and ready after reset.
    for (int r = 0; r < NREG; r++) begin
      s = idle();
      s.rd_en = '1;
      s.rd_addr[0 +: AW]  = AW'(r);
      s.rd_addr[AW +: AW] = AW'(NREG - 1 - r);
      apply(s);
    end

    // Sign-extend word through port 0 with same-cycle bypass, then stored.
    s = idle();
    s.wen0 = 1; s.waddr0 = 5; s.wdata0 = 64'h0000_0000_8000_0001; s.wext0 = 1;
    s.rd_addr[0 +: AW] = 5;
    apply(s);
    s = idle();
    s.rd_addr[0 +: AW] = 5;
    apply(s);

    // Byte sign/zero extension through port 1.
    s = idle();
    s.wen1 = 1; s.waddr1 = 7; s.wdata1 = 64'hAB; s.wext1 = 5;
    s.rd_addr[AW +: AW] = 7;
    apply(s);
    s = idle();
    s.rd_addr[AW +: AW] = 7;
    apply(s);
    s = idle();
    s.wen1 = 1; s.waddr1 = 7; s.wdata1 = 64'hAB; s.wext1 = 6;
    apply(s);
    s = idle();
    s.rd_addr[0 +: AW] = 7;
    apply(s);

    // Reserve x3, stall on it, then a clearing write releases it in the same cycle.
    s = idle();
    s.rsv_en = 1; s.rsv_addr = 3;
    apply(s);
    s = idle();
    s.rd_en = 2'b10; s.rd_addr[AW +: AW] = 3;
    apply(s);
    s.wen1 = 1; s.waddr1 = 3; s.wdata1 = 64'h1234_5678_9ABC_DEF0; s.wclr1 = 1;
    apply(s);

    // Clear and reserve the same register: stays busy.
    s = idle();
    s.wen0 = 1; s.waddr0 = 9; s.wclr0 = 1; s.wdata0 = 64'h99; s.rsv_en = 1; s.rsv_addr = 9;
    apply(s);
    s = idle();
    s.rd_en = 2'b01; s.rd_addr[0 +: AW] = 9;
    apply(s);

    // Collision on x4: port 1 wins and wcollide sticks; x0 traffic is inert.
    s = idle();
    s.wen0 = 1; s.waddr0 = 4; s.wdata0 = 64'h11;
    s.wen1 = 1; s.waddr1 = 4; s.wdata1 = 64'h22;
    apply(s);
    s = idle();
    s.rd_addr[0 +: AW] = 4;
    apply(s);
    s = idle();
    s.wen0 = 1; s.waddr0 = 0; s.wdata0 = '1; s.wclr0 = 1;
    s.wen1 = 1; s.waddr1 = 0; s.wdata1 = '1;
    s.rsv_en = 1; s.rsv_addr = 0; s.rd_en = '1;
    apply(s);
    s = idle();
    s.rd_en = '1;
    s.rd_addr[AW +: AW] = 4;
    apply(s);

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst_n    = ($urandom_range(0, 299) != 0);
      s.wen0     = 1'($urandom);
      s.waddr0   = rand_addr();
      s.wdata0   = {$urandom, $urandom};
      s.wext0    = 3'($urandom);
      s.wclr0    = 1'($urandom);
      s.wen1     = 1'($urandom);
      s.waddr1   = rand_addr();
      s.wdata1   = {$urandom, $urandom};
      s.wext1    = 3'($urandom);
      s.wclr1    = 1'($urandom);
      s.rsv_en   = ($urandom_range(0, 2) == 0);
      s.rsv_addr = rand_addr();
      s.rd_en    = NRD'($urandom);
      for (int i = 0; i < NRD; i++) s.rd_addr[i*AW +: AW] = rand_addr();
      apply(s);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
